iob_unpack_sched: RTL
=====================

# iob_unpack_sched

Round-robin scheduler that time-shares one `iob_unpack` instance among `N_CH` requester channels. Each channel supplies its own unpack width, wrap mode and burst length. The block arbitrates, loads the winner's configuration, and flushes the unpacker between bursts. During a burst it muxes the winner's packed-input and unpacked-output handshakes onto the shared unpacker and counts delivered words. It sits between the channel FIFOs and the single unpacker datapath.

## Interface
Parameters:
- `N_CH`, 4: number of requester channels (2..8).
- `DATA_W`, 21: unpacker data width. Must match the attached `iob_unpack`.
- `LEN_W`, 8: burst-length counter width.

Ports (`WW` = $clog2(DATA_W)+1, `CW` = $clog2(N_CH)):
- `clk_i` input 1: clock.
- `cke_i` input 1: clock enable. All registers hold when low.
- `arst_n_i` input 1: reset, asynchronous, active-low.
- `req_i` input N_CH: per-channel burst request (level).
- `width_i` input N_CH*WW: per-channel unpack width. Channel c occupies bits [c*WW +: WW].
- `wrap_i` input N_CH: per-channel wrap mode.
- `len_i` input N_CH*LEN_W: per-channel burst length in unpacked words.
- `gnt_o` output N_CH: one-hot grant. High from FLUSH through DONE.
- `done_o` output N_CH: one-cycle pulse when a channel's burst completes.
- `err_o` output N_CH: one-cycle pulse when a burst is rejected for an illegal width.
- `ch_rready_i` input N_CH: per-channel packed-input ready.
- `ch_read_o` output N_CH: per-channel packed-input read strobe.
- `ch_rdata_i` input N_CH*DATA_W: per-channel packed data.
- `ch_wready_i` input N_CH: per-channel unpacked-output ready.
- `ch_write_o` output N_CH: per-channel unpacked-output write strobe.
- `ch_wdata_o` output DATA_W: unpacked data, broadcast to all channels.
- `unp_rst_o` output 1: drives unpacker `rst_i`.
- `unp_wrap_o` output 1: drives unpacker `wrap_i`.
- `unp_width_o` output WW: drives unpacker `width_i`.
- `unp_rready_o` output 1: drives unpacker `rready_i`.
- `unp_rdata_o` output DATA_W: drives unpacker `rdata_i`.
- `unp_read_i` input 1: from unpacker `read_o`.
- `unp_wready_o` output 1: drives unpacker `wready_i`.
- `unp_write_i` input 1: from unpacker `write_o`.
- `unp_wdata_i` input DATA_W: from unpacker `wdata_o`.

## Operation
- States: IDLE, FLUSH, RUN, DONE. All state is held in registers with asynchronous reset (`arst_n_i` low).
- IDLE:
  - Round-robin search starts at `(last+1) mod N_CH`. `last` resets to N_CH-1, so channel 0 has first priority.
  - On any `req_i` bit set: latch the winner index, its `width`, `wrap` and `len`. Clear the word counter. Go to FLUSH.
  - If the latched width is 0 or greater than DATA_W: pulse `err_o[ch]`, set `last`=ch, and stay in IDLE. The grant is never raised.
- FLUSH: exactly 1 cycle. `gnt_o[ch]`=1, and the unpacker is held in reset while seeing the new config. Go to RUN, or go to DONE if `len`==0.
- RUN:
  - Handshakes are muxed for the granted channel only:
    - `unp_rready_o`=`ch_rready_i[ch]`, `unp_rdata_o`=`ch_rdata_i[ch]`, `ch_read_o[ch]`=`unp_read_i`.
    - `unp_wready_o`=`ch_wready_i[ch]`, `ch_write_o[ch]`=`unp_write_i`.
  - All other `ch_read_o` and `ch_write_o` bits are 0.
  - Each `unp_write_i` increments the counter. A write seen while counter==len-1 moves to DONE.
- DONE: 1 cycle. Pulse `done_o[ch]`, set `last`=ch, go to IDLE. `gnt_o` drops on entry to IDLE.
- `unp_rst_o`=1 in IDLE, FLUSH and DONE, and 0 only in RUN.
- `unp_rready_o` and `unp_wready_o` are 0 outside RUN.
- `unp_width_o` and `unp_wrap_o` always reflect the latched config. `ch_wdata_o`=`unp_wdata_i`.
- Config is latched at grant. `req_i`, `width_i`, `wrap_i` and `len_i` changes after grant are ignored. Deasserting `req_i` mid-burst does not abort the burst.
- Packed bits the unpacker read ahead but did not emit are discarded by the flush. Producers size their input to exactly the burst.

## Timing
- Reset values: state=IDLE, `gnt_o`=0, `done_o`=0, `err_o`=0, counter=0, latched width/wrap=0. Consequently `unp_rst_o`=1, `unp_rready_o`=0, `unp_wready_o`=0, and all `ch_read_o` and `ch_write_o` bits are 0.
- Cycle sequence:
  - Request seen in IDLE at cycle t.
  - `gnt_o` high at t+1 (FLUSH).
  - RUN from t+2; the first unpacked word can be accepted from t+2 onward.
  - DONE is the cycle after the last write, with `done_o` high in that cycle.
  - IDLE follows, and it can arbitrate in that same cycle.
- Overhead between bursts: 3 cycles (DONE, IDLE, FLUSH).
- Simultaneous requests: the lowest index at or after `last+1`, with wrap-around, wins.
- Mid-operation reset: everything returns to reset values immediately and asynchronously. The unpacker is held in reset by `unp_rst_o`.
- Counter is LEN_W bits wide and compares against the latched `len`. It never wraps because `len` is at most 2^LEN_W-1.

## Test plan
- Single channel, DATA_W=21, width=7, wrap=0, len=6, with ready inputs always high:
  - `gnt_o`=0001 one cycle after `req_i[0]`.
  - Exactly 6 `ch_write_o[0]` pulses carrying the 7-bit fields in order.
  - `done_o[0]` one cycle after the 6th write, and `unp_rst_o`=1 again the cycle after.
- All 4 channels requesting continuously, len=2 each: grant order 0,1,2,3,0, with 3 idle cycles between the last write of one burst and the first RUN cycle of the next.
- Ch1 width=5 wrap=1, then ch2 width=21 wrap=0:
  - `unp_width_o` and `unp_wrap_o` switch only during FLUSH.
  - Ch2 output words are unaffected by ch1's leftover bits.
- Illegal width: `width_i[ch3]`=0 or 22 produces an `err_o[3]` pulse and no `gnt_o[3]`. Ch0 is then granted on the next cycle if it is requesting.
- Backpressure: with `ch_wready_i[0]` toggling every other cycle, only qualified writes are counted, and the counter reaches len exactly once. `ch_read_o` and `ch_write_o` for non-granted channels stay 0 throughout.
- Assert `arst_n_i` low mid-RUN (after 3 of 6 writes): all outputs go to reset values immediately. After release, channel 0 is re-granted with the counter restarted at 0.

Source files
------------

// File: rtl/iob_unpack_sched.sv
// Round-robin scheduler time-sharing one iob_unpack among N_CH channels.
// Latches the winner's config at grant, flushes the unpacker, muxes handshakes and counts words.
module iob_unpack_sched #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 21,
   parameter int LEN_W  = 8,
   localparam int WW    = $clog2(DATA_W) + 1,
   localparam int CW    = $clog2(N_CH)
) (
   input  logic                     clk_i,
   input  logic                     cke_i,
   input  logic                     arst_n_i,
   input  logic [N_CH-1:0]          req_i,
   input  logic [N_CH*WW-1:0]       width_i,
   input  logic [N_CH-1:0]          wrap_i,
   input  logic [N_CH*LEN_W-1:0]    len_i,
   output logic [N_CH-1:0]          gnt_o,
   output logic [N_CH-1:0]          done_o,
   output logic [N_CH-1:0]          err_o,
   input  logic [N_CH-1:0]          ch_rready_i,
   output logic [N_CH-1:0]          ch_read_o,
   input  logic [N_CH*DATA_W-1:0]   ch_rdata_i,
   input  logic [N_CH-1:0]          ch_wready_i,
   output logic [N_CH-1:0]          ch_write_o,
   output logic [DATA_W-1:0]        ch_wdata_o,
   output logic                     unp_rst_o,
   output logic                     unp_wrap_o,
   output logic [WW-1:0]            unp_width_o,
   output logic                     unp_rready_o,
   output logic [DATA_W-1:0]        unp_rdata_o,
   input  logic                     unp_read_i,
   output logic                     unp_wready_o,
   input  logic                     unp_write_i,
   input  logic [DATA_W-1:0]        unp_wdata_i
);

   typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     ch, last, win;
   logic              win_vld, win_legal;
   logic [WW-1:0]     win_width;
   logic [WW-1:0]     width;
   logic              wrap;
   logic [LEN_W-1:0]  len, cnt;
   logic [N_CH-1:0]   err, onehot;
   logic              run;

   // Search order starts just after the last served channel, wrapping around.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         if (!win_vld && req_i[CW'((32'(last) + k) % N_CH)]) begin
            win_vld = 1'b1;
            win     = CW'((32'(last) + k) % N_CH);
         end
      end
   end

   assign win_width = width_i[32'(win)*WW +: WW];
   assign win_legal = (win_width != '0) && (win_width <= WW'(DATA_W));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (win_vld && win_legal) state_nx = FLUSH;
         FLUSH:   state_nx = (len == '0) ? DONE : RUN;
         RUN:     if (unp_write_i && (cnt == len - 1'b1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state <= IDLE;
         ch    <= '0;
         last  <= CW'(N_CH - 1);
         width <= '0;
         wrap  <= 1'b0;
         len   <= '0;
         cnt   <= '0;
         err   <= '0;
      end else if (cke_i) begin
         state <= state_nx;
         err   <= '0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  if (win_legal) begin
                     ch    <= win;
                     width <= win_width;
                     wrap  <= wrap_i[win];
                     len   <= len_i[32'(win)*LEN_W +: LEN_W];
                     cnt   <= '0;
                  end else begin
                     // rejected request still advances round-robin so others are not starved
                     err[win] <= 1'b1;
                     last     <= win;
                  end
               end
            end
            RUN:     if (unp_write_i) cnt <= cnt + 1'b1;
            DONE:    last <= ch;
            default: ;
         endcase
      end
   end

   assign onehot = N_CH'(1) << ch;
   assign run    = (state == RUN);

   assign gnt_o        = (state != IDLE) ? onehot : '0;
   assign done_o       = (state == DONE) ? onehot : '0;
   assign err_o        = err;
   assign unp_rst_o    = !run;
   assign unp_wrap_o   = wrap;
   assign unp_width_o  = width;
   assign unp_rready_o = run && ch_rready_i[ch];
   assign unp_wready_o = run && ch_wready_i[ch];
   assign unp_rdata_o  = ch_rdata_i[32'(ch)*DATA_W +: DATA_W];
   assign ch_read_o    = (run && unp_read_i)  ? onehot : '0;
   assign ch_write_o   = (run && unp_write_i) ? onehot : '0;
   assign ch_wdata_o   = unp_wdata_i;

endmodule
